skinny_sbox8_inv_ti2_pipelined: RTL



---
 rtl/skinny_sbox8_ti_pkg.sv | 20 ++
 rtl/skinny_sbox8_inv_ti2_pipelined_cfn_reg.sv | 20 ++
 rtl/skinny_sbox8_inv_ti2_pipelined.sv | 62 ++++++
 3 files changed

// File: rtl/skinny_sbox8_ti_pkg.sv
// skinny_sbox8_ti_pkg: constants and types for the three-share inverse SKINNY 8-bit S-box pipeline
package skinny_sbox8_ti_pkg;
    localparam int LATENCY = 4;
    typedef logic [2:0][7:0] shares_t;
    // per stage: working bits rewritten by a shared NOR-XOR step, and the two NOR operands of each
    localparam logic [7:0] STEP_MASK [LATENCY] = '{8'h93, 8'h28, 8'h04, 8'h40};
    localparam logic [2:0] NOR_A [LATENCY][8] = '{
        '{3'd3, 3'd2, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd6},
        '{3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd4, 3'd0, 3'd0},
        '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
        '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0}
    };
    localparam logic [2:0] NOR_B [LATENCY][8] = '{
        '{3'd1, 3'd7, 3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 3'd5},
        '{3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0},
        '{3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
        '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0}
    };
    localparam logic [2:0] OUT_MAP [8] = '{3'd5, 3'd3, 3'd0, 3'd4, 3'd6, 3'd7, 3'd2, 3'd1};
endpackage

// File: rtl/skinny_sbox8_inv_ti2_pipelined_cfn_reg.sv
// ti2_sbox8_inv_cfn_reg: registered three-share NOR-XOR step q <= NOR(a,b) ^ z, non-complete per share
module ti2_sbox8_inv_cfn_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic [2:0] z,
    output logic [2:0] q
);
    logic [2:0] x, y, f;
    assign x = {a[2:1], ~a[0]};
    assign y = {b[2:1], ~b[0]};
    assign f = {x[0] & y[0] ^ x[0] & y[1] ^ x[1] & y[0] ^ z[2],
                x[2] & y[2] ^ x[0] & y[2] ^ x[2] & y[0] ^ z[1],
                x[1] & y[1] ^ x[1] & y[2] ^ x[2] & y[1] ^ z[0]};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en) q <= f;
endmodule

// File: rtl/skinny_sbox8_inv_ti2_pipelined.sv
// skinny_sbox8_inv_ti2_pipelined: 4-stage three-share inverse SKINNY S-box with valid/ready flow control
module skinny_sbox8_inv_ti2_pipelined
    import skinny_sbox8_ti_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] si0,
    input  logic [7:0] si1,
    input  logic [7:0] si2,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] bo0,
    output logic [7:0] bo1,
    output logic [7:0] bo2
);
    logic [2:0] p [LATENCY][8];
    logic [2:0] r [LATENCY][8];
    logic [LATENCY-1:0] v;
    logic advance;
    shares_t bo;
    assign advance = ~v[LATENCY-1] | out_ready;
    assign in_ready = advance;
    assign out_valid = v[LATENCY-1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) v <= '0;
        else if (advance) v <= {v[LATENCY-2:0], in_valid};
    // every working bit is registered at every stage, so each nonlinear layer sees only flops
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        for (genvar i = 0; i < 8; i++) begin : g_bit
            if (k == 0) begin : g_src
                assign p[k][i] = {si2[i], si1[i], si0[i]};
            end else begin : g_src
                assign p[k][i] = r[k-1][i];
            end
            if (STEP_MASK[k][i]) begin : g_reg
                ti2_sbox8_inv_cfn_reg u_cfn (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (advance),
                    .a     (p[k][NOR_A[k][i]]),
                    .b     (p[k][NOR_B[k][i]]),
                    .z     (p[k][i]),
                    .q     (r[k][i])
                );
            end else begin : g_reg
                always_ff @(posedge clk or negedge rst_n)
                    if (!rst_n) r[k][i] <= '0;
                    else if (advance) r[k][i] <= p[k][i];
            end
        end
    end
    for (genvar s = 0; s < 3; s++) begin : g_share
        for (genvar j = 0; j < 8; j++) begin : g_out
            assign bo[s][j] = r[LATENCY-1][OUT_MAP[j]][s];
        end
    end
    assign bo0 = bo[0];
    assign bo1 = bo[1];
    assign bo2 = bo[2];
endmodule
